// File: rtl/rd_arb_nch_if.sv
// Signal bundle between the N-channel read arbiter, its requesters and the AXI read port.
// The master view belongs to the arbiter; the slave view to the requesters and memory side.
interface rd_arb_nch_if #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ID_WIDTH   = 4
);
  logic [NUM_CH-1:0]            req_valid;
  logic [NUM_CH-1:0]            req_ready;
  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_CH-1:0]            rsp_valid;
  logic [NUM_CH-1:0]            rsp_ready;
  logic [DATA_WIDTH-1:0]        rsp_data;
  logic                         rsp_last;
  logic                         err_unexp;
  logic [NUM_CH-1:0]            err_resp;
  logic                         axi_rready;
  logic [ID_WIDTH-1:0]          axi_rid;
  logic [ADDR_WIDTH-1:0]        axi_raddr;
  logic [7:0]                   axi_rlen;
  logic [2:0]                   axi_rsize;
  logic [1:0]                   axi_rburst;
  logic                         axi_rlock;
  logic [3:0]                   axi_rcache;
  logic [2:0]                   axi_rprot;
  logic                         axi_rvalid;
  logic [ID_WIDTH-1:0]          axi_rd_bid;
  logic [1:0]                   axi_rd_rresp;
  logic                         axi_rd_rvalid;
  logic [DATA_WIDTH-1:0]        axi_rd_data;
  logic                         axi_rd_last;
  logic                         axi_rd_rready;

  modport master (
    input  req_valid, req_addr, rsp_ready, axi_rready, axi_rd_bid, axi_rd_rresp,
           axi_rd_rvalid, axi_rd_data, axi_rd_last,
    output req_ready, rsp_valid, rsp_data, rsp_last, err_unexp, err_resp, axi_rid,
           axi_raddr, axi_rlen, axi_rsize, axi_rburst, axi_rlock, axi_rcache, axi_rprot,
           axi_rvalid, axi_rd_rready
  );

  modport slave (
    output req_valid, req_addr, rsp_ready, axi_rready, axi_rd_bid, axi_rd_rresp,
           axi_rd_rvalid, axi_rd_data, axi_rd_last,
    input  req_ready, rsp_valid, rsp_data, rsp_last, err_unexp, err_resp, axi_rid,
           axi_raddr, axi_rlen, axi_rsize, axi_rburst, axi_rlock, axi_rcache, axi_rprot,
           axi_rvalid, axi_rd_rready
  );
endinterface

// File: rtl/rd_arb_nch.sv
// Round-robin N-channel AXI read arbiter: one registered AR slot, per-channel outstanding
// limits, and a zero-latency R path routed to the requester by ID.
module rd_arb_nch #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned BURST_LEN  = 1,
  parameter int unsigned MAX_OUTST  = 4
) (
  input logic          aclk,
  input logic          aresetn,
  rd_arb_nch_if.master bus
);
  localparam int unsigned     OutW   = $clog2(MAX_OUTST + 1);
  localparam logic [OutW-1:0] MaxOut = OutW'(MAX_OUTST);
  localparam logic [OutW-1:0] One    = OutW'(1);

  logic                  rvalid_q, rvalid_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic [OutW-1:0]       outst_q [NUM_CH];
  logic [OutW-1:0]       outst_d [NUM_CH];
  logic                  err_unexp_q, err_unexp_d;
  logic [NUM_CH-1:0]     err_resp_q, err_resp_d;

  logic                  ar_free, found, route_hit, beat_acc;
  logic [ID_WIDTH-1:0]   grant;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [NUM_CH-1:0]     eligible, accept, route_sel;

  assign ar_free = !rvalid_q || bus.axi_rready;

  // Two passes implement the rotation: channels above last_q first, then wrap to the rest.
  always_comb begin
    found      = 1'b0;
    grant      = '0;
    grant_addr = '0;
    eligible   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = bus.req_valid[i] && (outst_q[i] < MaxOut);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && eligible[i] && (i > int'(last_q))) begin
        found      = 1'b1;
        grant      = ID_WIDTH'(i);
        grant_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && eligible[i] && (i <= int'(last_q))) begin
        found      = 1'b1;
        grant      = ID_WIDTH'(i);
        grant_addr = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // A beat only routes to a channel that is actually waiting for one; anything else is drained.
  always_comb begin
    accept    = '0;
    route_sel = '0;
    route_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      accept[i] = aresetn && ar_free && found && (grant == ID_WIDTH'(i));
      if ((bus.axi_rd_bid == ID_WIDTH'(i)) && (outst_q[i] != '0)) begin
        route_hit    = 1'b1;
        route_sel[i] = 1'b1;
      end
    end
  end

  assign bus.axi_rd_rready = route_hit ? |(route_sel & bus.rsp_ready) : 1'b1;
  assign beat_acc          = bus.axi_rd_rvalid && bus.axi_rd_rready;

  always_comb begin
    rvalid_d    = rvalid_q;
    rid_d       = rid_q;
    raddr_d     = raddr_q;
    last_d      = last_q;
    err_unexp_d = err_unexp_q | (beat_acc & ~route_hit);
    err_resp_d  = err_resp_q;
    outst_d     = outst_q;
    if (ar_free) begin
      rvalid_d = found;
      if (found) begin
        rid_d   = grant;
        raddr_d = grant_addr;
        last_d  = grant;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (beat_acc && route_sel[i] && (bus.axi_rd_rresp != 2'b00)) begin
        err_resp_d[i] = 1'b1;
      end
      case ({accept[i], beat_acc && route_sel[i] && bus.axi_rd_last})
        2'b10:   outst_d[i] = outst_q[i] + One;
        2'b01:   outst_d[i] = outst_q[i] - One;
        default: outst_d[i] = outst_q[i];
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid_q    <= 1'b0;
      rid_q       <= '0;
      raddr_q     <= '0;
      last_q      <= ID_WIDTH'(NUM_CH - 1);
      err_unexp_q <= 1'b0;
      err_resp_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        outst_q[i] <= '0;
      end
    end else begin
      rvalid_q    <= rvalid_d;
      rid_q       <= rid_d;
      raddr_q     <= raddr_d;
      last_q      <= last_d;
      err_unexp_q <= err_unexp_d;
      err_resp_q  <= err_resp_d;
      for (int i = 0; i < NUM_CH; i++) begin
        outst_q[i] <= outst_d[i];
      end
    end
  end

  assign bus.req_ready  = accept;
  assign bus.rsp_valid  = route_sel & {NUM_CH{bus.axi_rd_rvalid}};
  assign bus.rsp_data   = bus.axi_rd_data;
  assign bus.rsp_last   = bus.axi_rd_last;
  assign bus.err_unexp  = err_unexp_q;
  assign bus.err_resp   = err_resp_q;
  assign bus.axi_rvalid = rvalid_q;
  assign bus.axi_rid    = rid_q;
  assign bus.axi_raddr  = raddr_q;
  assign bus.axi_rlen   = 8'(BURST_LEN - 1);
  assign bus.axi_rsize  = 3'($clog2(DATA_WIDTH / 8));
  assign bus.axi_rburst = 2'b01;
  assign bus.axi_rlock  = 1'b0;
  assign bus.axi_rcache = 4'b0011;
  assign bus.axi_rprot  = 3'b000;
endmodule

// File: tb/tb_rd_arb_nch.sv
// Directed bench for rd_arb_nch: inputs change 1 ns after the rising edge, outputs are
// sampled 1 ns later so both registered and combinational paths have settled.
module tb_rd_arb_nch;
  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 512;
  localparam int unsigned ID_WIDTH   = 4;
  localparam int unsigned BURST_LEN  = 1;
  localparam int unsigned MAX_OUTST  = 4;

  localparam logic [DATA_WIDTH-1:0] D1 = {16{32'hCAFE_0001}};
  localparam logic [DATA_WIDTH-1:0] D2 = {16{32'h5A5A_1234}};
  localparam logic [DATA_WIDTH-1:0] D3 = {16{32'h0BAD_F00D}};

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 aclk = ~aclk;

  rd_arb_nch_if #(
    .NUM_CH(NUM_CH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) bus ();

  rd_arb_nch #(
    .NUM_CH(NUM_CH), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH),
    .BURST_LEN(BURST_LEN), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .bus(bus)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid     = '0;
    bus.req_addr      = '0;
    bus.rsp_ready     = '0;
    bus.axi_rready    = 1'b1;
    bus.axi_rd_bid    = '0;
    bus.axi_rd_rresp  = 2'b00;
    bus.axi_rd_rvalid = 1'b0;
    bus.axi_rd_data   = '0;
    bus.axi_rd_last   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_addr  = {32'h3000, 32'h2000, 32'h1000};
    bus.axi_rd_rvalid = 1'b1;
    bus.axi_rd_bid    = 4'd0;
    repeat (2) tick();
    #1;
    checks++; if (bus.req_ready !== 3'b000) begin errors++;
      $display("FAIL reset_req_ready: got %b exp 000", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 3'b000) begin errors++;
      $display("FAIL reset_rsp_valid: got %b exp 000", bus.rsp_valid); end
    checks++; if (bus.axi_rd_rready !== 1'b1) begin errors++;
      $display("FAIL reset_rd_rready: got %b exp 1", bus.axi_rd_rready); end
    checks++; if (bus.axi_rvalid !== 1'b0) begin errors++;
      $display("FAIL reset_rvalid: got %b exp 0", bus.axi_rvalid); end
    checks++; if (bus.axi_rid !== 4'd0) begin errors++;
      $display("FAIL reset_rid: got %0d exp 0", bus.axi_rid); end
    checks++; if (bus.axi_raddr !== 32'h0) begin errors++;
      $display("FAIL reset_raddr: got %h exp 0", bus.axi_raddr); end
    checks++; if (bus.err_unexp !== 1'b0 || bus.err_resp !== 3'b000) begin errors++;
      $display("FAIL reset_err: got %b/%b exp 0/000", bus.err_unexp, bus.err_resp); end
    checks++; if (bus.axi_rlen !== 8'd0 || bus.axi_rsize !== 3'd6) begin errors++;
      $display("FAIL const_len_size: got %0d/%0d exp 0/6", bus.axi_rlen, bus.axi_rsize); end
    checks++; if ({bus.axi_rburst, bus.axi_rlock, bus.axi_rcache, bus.axi_rprot}
                  !== {2'b01, 1'b0, 4'b0011, 3'b000}) begin errors++;
      $display("FAIL const_attr: got burst %b lock %b cache %b prot %b exp 01 0 0011 000",
               bus.axi_rburst, bus.axi_rlock, bus.axi_rcache, bus.axi_rprot); end
    idle_inputs();
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.req_valid = 3'b010;
    bus.req_addr[1*ADDR_WIDTH +: ADDR_WIDTH] = 32'h0000_1000;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++;
      $display("FAIL single_req_ready: got %b exp 010", bus.req_ready); end
    tick();
    checks++; if ({bus.axi_rvalid, bus.axi_rid, bus.axi_raddr} !== {1'b1, 4'd1, 32'h1000})
      begin errors++;
      $display("FAIL single_ar: got v%b id%0d a%h exp v1 id1 a00001000",
               bus.axi_rvalid, bus.axi_rid, bus.axi_raddr); end
    bus.req_valid = '0;
    tick();
    checks++; if (bus.axi_rvalid !== 1'b0) begin errors++;
      $display("FAIL single_ar_drop: got %b exp 0", bus.axi_rvalid); end
    bus.axi_rd_rvalid = 1'b1;
    bus.axi_rd_bid    = 4'd1;
    bus.axi_rd_last   = 1'b1;
    bus.axi_rd_data   = D1;
    bus.rsp_ready     = 3'b010;
    #1;
    checks++; if ({bus.rsp_valid, bus.axi_rd_rready, bus.rsp_last} !== {3'b010, 1'b1, 1'b1})
      begin errors++;
      $display("FAIL single_rsp: got v%b rr%b l%b exp v010 rr1 l1",
               bus.rsp_valid, bus.axi_rd_rready, bus.rsp_last); end
    checks++; if (bus.rsp_data !== D1) begin errors++;
      $display("FAIL single_rsp_data: got %h exp %h", bus.rsp_data, D1); end
    tick();
    // The repeated beat must now be unexpected, proving the count returned to zero.
    checks++; if ({bus.rsp_valid, bus.axi_rd_rready, bus.err_unexp} !== {3'b000, 1'b1, 1'b0})
      begin errors++;
      $display("FAIL single_outst_zero: got v%b rr%b e%b exp v000 rr1 e0",
               bus.rsp_valid, bus.axi_rd_rready, bus.err_unexp); end
    tick();
    checks++; if (bus.err_unexp !== 1'b1) begin errors++;
      $display("FAIL single_stray_flag: got %b exp 1", bus.err_unexp); end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rr;
    do_reset();
    bus.req_valid = 3'b111;
    bus.rsp_ready = 3'b111;
    for (int k = 0; k < 30; k++) begin
      bus.axi_rd_rvalid = bus.axi_rvalid;
      bus.axi_rd_bid    = bus.axi_rid;
      bus.axi_rd_last   = 1'b1;
      exp_rr = 3'b001 << (k % 3);
      #1;
      checks++; if (bus.req_ready !== exp_rr) begin errors++;
        $display("FAIL rr_grant[%0d]: got %b exp %b", k, bus.req_ready, exp_rr); end
      tick();
    end
    checks++; if (bus.err_unexp !== 1'b0) begin errors++;
      $display("FAIL rr_no_unexp: got %b exp 0", bus.err_unexp); end
    idle_inputs();
  endtask

  task automatic test_max_outst();
    logic [2:0] exp_rdy;
    do_reset();
    bus.req_valid = 3'b001;
    bus.req_addr[0 +: ADDR_WIDTH] = 32'h0000_4000;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = (k < 4) ? 3'b001 : 3'b000;
      #1;
      checks++; if (bus.req_ready !== exp_rdy) begin errors++;
        $display("FAIL outst_accept[%0d]: got %b exp %b", k, bus.req_ready, exp_rdy); end
      tick();
    end
    bus.axi_rd_rvalid = 1'b1;
    bus.axi_rd_bid    = 4'd0;
    bus.axi_rd_last   = 1'b1;
    bus.rsp_ready     = 3'b001;
    #1;
    checks++; if ({bus.rsp_valid, bus.axi_rd_rready, bus.req_ready} !== {3'b001, 1'b1, 3'b000})
      begin errors++;
      $display("FAIL outst_release: got v%b rr%b rdy%b exp v001 rr1 rdy000",
               bus.rsp_valid, bus.axi_rd_rready, bus.req_ready); end
    tick();
    bus.axi_rd_rvalid = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++;
      $display("FAIL outst_fifth: got %b exp 001", bus.req_ready); end
    tick();
    checks++; if (bus.req_ready !== 3'b000) begin errors++;
      $display("FAIL outst_full_again: got %b exp 000", bus.req_ready); end
    idle_inputs();
  endtask

  task automatic test_ar_stall();
    do_reset();
    bus.axi_rready = 1'b0;
    bus.req_valid  = 3'b011;
    bus.req_addr[0*ADDR_WIDTH +: ADDR_WIDTH] = 32'h0000_A000;
    bus.req_addr[1*ADDR_WIDTH +: ADDR_WIDTH] = 32'h0000_B000;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++;
      $display("FAIL stall_first: got %b exp 001", bus.req_ready); end
    tick();
    bus.req_addr[0*ADDR_WIDTH +: ADDR_WIDTH] = 32'hDEAD_0000;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if ({bus.axi_rvalid, bus.axi_rid, bus.axi_raddr, bus.req_ready}
                    !== {1'b1, 4'd0, 32'h0000_A000, 3'b000}) begin errors++;
        $display("FAIL stall_hold[%0d]: got v%b id%0d a%h rdy%b exp v1 id0 a0000a000 rdy000",
                 k, bus.axi_rvalid, bus.axi_rid, bus.axi_raddr, bus.req_ready); end
      tick();
    end
    bus.axi_rready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin errors++;
      $display("FAIL stall_release: got %b exp 010", bus.req_ready); end
    tick();
    checks++; if ({bus.axi_rvalid, bus.axi_rid, bus.axi_raddr} !== {1'b1, 4'd1, 32'h0000_B000})
      begin errors++;
      $display("FAIL stall_next_ar: got v%b id%0d a%h exp v1 id1 a0000b000",
               bus.axi_rvalid, bus.axi_rid, bus.axi_raddr); end
    idle_inputs();
  endtask

  task automatic test_rsp_backpressure();
    do_reset();
    bus.req_valid = 3'b100;
    bus.req_addr[2*ADDR_WIDTH +: ADDR_WIDTH] = 32'h0000_2000;
    #1;
    checks++; if (bus.req_ready !== 3'b100) begin errors++;
      $display("FAIL bp_accept: got %b exp 100", bus.req_ready); end
    tick();
    bus.req_valid     = '0;
    bus.axi_rd_rvalid = 1'b1;
    bus.axi_rd_bid    = 4'd2;
    bus.axi_rd_last   = 1'b1;
    bus.axi_rd_data   = D3;
    bus.rsp_ready     = 3'b000;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if ({bus.axi_rd_rready, bus.rsp_valid} !== {1'b0, 3'b100}) begin errors++;
        $display("FAIL bp_hold[%0d]: got rr%b v%b exp rr0 v100",
                 k, bus.axi_rd_rready, bus.rsp_valid); end
      tick();
    end
    bus.rsp_ready = 3'b100;
    #1;
    checks++; if ({bus.axi_rd_rready, bus.rsp_data} !== {1'b1, D3}) begin errors++;
      $display("FAIL bp_accept_beat: got rr%b d%h exp rr1", bus.axi_rd_rready, bus.rsp_data); end
    tick();
    bus.axi_rd_bid = 4'd7;
    #1;
    checks++; if ({bus.rsp_valid, bus.axi_rd_rready, bus.err_unexp} !== {3'b000, 1'b1, 1'b0})
      begin errors++;
      $display("FAIL bp_bad_id: got v%b rr%b e%b exp v000 rr1 e0",
               bus.rsp_valid, bus.axi_rd_rready, bus.err_unexp); end
    tick();
    checks++; if (bus.err_unexp !== 1'b1) begin errors++;
      $display("FAIL bp_bad_id_flag: got %b exp 1", bus.err_unexp); end
    idle_inputs();
  endtask

  task automatic test_rresp_and_reset();
    do_reset();
    bus.axi_rready = 1'b0;
    bus.req_valid  = 3'b001;
    bus.req_addr[0 +: ADDR_WIDTH] = 32'h0000_3000;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++;
      $display("FAIL err_accept1: got %b exp 001", bus.req_ready); end
    tick();
    bus.axi_rready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin errors++;
      $display("FAIL err_accept2: got %b exp 001", bus.req_ready); end
    tick();
    bus.req_valid     = '0;
    bus.axi_rready    = 1'b0;
    bus.axi_rd_rvalid = 1'b1;
    bus.axi_rd_bid    = 4'd0;
    bus.axi_rd_rresp  = 2'b10;
    bus.axi_rd_last   = 1'b1;
    bus.axi_rd_data   = D2;
    bus.rsp_ready     = 3'b001;
    #1;
    checks++; if ({bus.rsp_valid, bus.rsp_data, bus.err_resp} !== {3'b001, D2, 3'b000})
      begin errors++;
      $display("FAIL err_deliver: got v%b e%b d%h exp v001 e000",
               bus.rsp_valid, bus.err_resp, bus.rsp_data); end
    tick();
    bus.axi_rd_rvalid = 1'b0;
    bus.axi_rd_rresp  = 2'b00;
    checks++; if ({bus.err_resp, bus.axi_rvalid} !== {3'b001, 1'b1}) begin errors++;
      $display("FAIL err_resp_flag: got e%b v%b exp e001 v1", bus.err_resp, bus.axi_rvalid); end
    // Asynchronous reset with one AR pending and one burst still outstanding.
    aresetn = 1'b0;
    bus.req_valid = 3'b001;
    #1;
    checks++; if ({bus.axi_rvalid, bus.axi_rid, bus.axi_raddr, bus.err_resp, bus.req_ready}
                  !== {1'b0, 4'd0, 32'h0, 3'b000, 3'b000}) begin errors++;
      $display("FAIL midreset_clear: got v%b id%0d a%h e%b rdy%b exp all zero",
               bus.axi_rvalid, bus.axi_rid, bus.axi_raddr, bus.err_resp, bus.req_ready); end
    bus.req_valid     = '0;
    bus.axi_rd_rvalid = 1'b1;
    bus.axi_rd_bid    = 4'd0;
    #1;
    checks++; if ({bus.rsp_valid, bus.axi_rd_rready} !== {3'b000, 1'b1}) begin errors++;
      $display("FAIL midreset_drain: got v%b rr%b exp v000 rr1",
               bus.rsp_valid, bus.axi_rd_rready); end
    @(negedge aclk);
    aresetn = 1'b1;
    tick();
    checks++; if (bus.err_unexp !== 1'b1) begin errors++;
      $display("FAIL midreset_stray_flag: got %b exp 1", bus.err_unexp); end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_max_outst();
    test_ar_stall();
    test_rsp_backpressure();
    test_rresp_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rd_arb_nch.md
# rd_arb_nch

Parametrised N-channel AXI read-channel arbiter in the DDR key/crypto datapath. Merges read requests from NUM_CH requesters (encrypt, decode, key-init, further channels) onto one AXI read address/data interface toward the MIG. Adds per-requester backpressure, per-channel outstanding-burst limits, ID-tagged response routing and error flagging. Sits on the MIG side of the clock-crossing FIFOs.

## Interface
- NUM_CH, 3, number of requesters (2..15, must be < 2^ID_WIDTH)
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 512, AXI data width
- ID_WIDTH, 4, AXI ID width; ID carries the channel index
- BURST_LEN, 1, beats per burst (1..256)
- MAX_OUTST, 4, max outstanding bursts per channel (1..15)

- aclk  in  1  clock; single clock domain
- aresetn  in  1  asynchronous, active-low reset
- req_valid  in  NUM_CH  per-channel read request
- req_ready  out  NUM_CH  request accepted this cycle
- req_addr  in  NUM_CH*ADDR_WIDTH  channel i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
- rsp_valid  out  NUM_CH  response beat valid for channel i (one-hot or zero)
- rsp_ready  in  NUM_CH  channel i accepts a beat
- rsp_data  out  DATA_WIDTH  beat data, shared by all channels
- rsp_last  out  1  last beat of burst
- err_unexp  out  1  sticky: beat with rid >= NUM_CH or for a channel with 0 outstanding
- err_resp  out  NUM_CH  sticky per channel: rresp != 0 seen
- axi_rready  in  1  AR ready
- axi_rid  out  ID_WIDTH  AR ID = granted channel index
- axi_raddr  out  ADDR_WIDTH  AR address
- axi_rlen  out  8  constant BURST_LEN-1
- axi_rsize  out  3  constant clog2(DATA_WIDTH/8) (6 at 512)
- axi_rburst  out  2  constant 2'b01 INCR
- axi_rlock / axi_rcache / axi_rprot  out  1/4/3  constants 0 / 4'b0011 / 0
- axi_rvalid  out  1  AR valid
- axi_rd_bid  in  ID_WIDTH  R ID
- axi_rd_rresp  in  2  R response
- axi_rd_rvalid  in  1  R valid
- axi_rd_data  in  DATA_WIDTH  R data
- axi_rd_last  in  1  R last
- axi_rd_rready  out  1  R ready

## Operation
- AR register (axi_rvalid, axi_rid, axi_raddr) is "free" when axi_rvalid=0 or axi_rvalid&axi_rready this cycle.
- Eligible channel: req_valid[i]=1 and outstanding[i] < MAX_OUTST.
- When free and any channel eligible: round-robin grant, searching from (last_grant+1) mod NUM_CH upward; req_ready[grant]=1 combinationally that cycle; register loads addr, rid=grant; last_grant updated. last_grant resets to NUM_CH-1 (channel 0 first priority).
- axi_rvalid/axi_raddr/axi_rid hold stable until axi_rready.
- outstanding[i]: width clog2(MAX_OUTST+1); +1 on req_ready[i] (acceptance, not AR handshake); -1 on R beat with last for channel i accepted; both same cycle -> unchanged.
- R routing: c = axi_rd_bid. If c < NUM_CH and outstanding[c] != 0: rsp_valid[c]=axi_rd_rvalid, axi_rd_rready=rsp_ready[c], rsp_data/rsp_last pass through combinationally.
- Otherwise: rsp_valid all 0, axi_rd_rready=1 (beat drained), err_unexp set on the beat.
- err_resp[c] set on any accepted beat for valid c with rresp != 0; beat still delivered.
- Error flags clear only on reset.

## Timing
- Reset values: axi_rvalid=0, axi_rid=0, axi_raddr=0, all outstanding=0, err_unexp=0, err_resp=0; req_ready/rsp_valid 0 while aresetn=0; axi_rd_rready=1 only if axi_rd_rvalid routes as unexpected.
- Request accepted in cycle N -> axi_rvalid=1 in N+1. Back-to-back: with axi_rready held 1, one AR per cycle.
- R path: zero latency (combinational), no buffering; rready never asserted toward a channel that is not ready.
- Channel at MAX_OUTST: ineligible until its last beat accepted; may re-grant in the same cycle as that decrement (decrement is visible next cycle).
- Reset mid-burst: state cleared immediately; R beats still arriving afterward are drained and flag err_unexp.

## Test plan
- Single request ch1 addr 0x0000_1000, axi_rready=1 -> axi_rvalid next cycle, rid=1, rlen=BURST_LEN-1, rsize=6; R beat rid=1 last -> rsp_valid=3'b010, outstanding[1] back to 0.
- All 3 channels valid continuously, axi_rready=1, R returned immediately -> grants 0,1,2,0,1,2; no starvation over 30 cycles.
- Ch0 only, R withheld, MAX_OUTST=4 -> exactly 4 accepts, req_ready[0]=0 after; one last beat -> fifth accept next cycle.
- axi_rready=0 for 5 cycles with AR pending -> axi_raddr/axi_rid stable, no further req_ready.
- R beat rid=2 with rsp_ready[2]=0 for 3 cycles -> axi_rd_rready=0 those cycles, accepted when rsp_ready[2]=1; beat rid=7 -> drained, err_unexp=1.
- rresp=2'b10 on ch0 beat -> err_resp=3'b001, data still delivered; aresetn low mid-burst -> all outputs at reset values, subsequent stray beat sets err_unexp.
